// File: rtl/dual_port_mem_pkg.sv
// Shared types and helpers for the dual-port memory with read pipeline.
package dual_port_mem_pkg;

  typedef enum logic [1:0] {
    MODE_READ_FIRST,
    MODE_WRITE_FIRST,
    MODE_NO_CHANGE
  } mode_e;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } clr_state_e;

  // Address width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dp_mem_rd_pipe.sv
// Read-data delay line: LATENCY stages of data+valid, flushed by reset.
// Each stage only loads data when its valid is set, so data_o holds between pulses.
module dp_mem_rd_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0] v_q;
  logic [WIDTH-1:0]   d_q [LATENCY];

  // Shift valid every cycle; advance data only alongside a valid token.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= valid_i;
      if (valid_i) d_q[0] <= data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign valid_o = v_q[LATENCY-1];
  assign data_o  = d_q[LATENCY-1];

endmodule

// File: rtl/dual_port_mem_pipe.sv
// True-dual-port RAM with byte enables, pipelined reads, collision
// arbitration and an optional post-reset clear sequencer.
module dual_port_mem_pipe
  import dual_port_mem_pkg::*;
#(
  parameter int unsigned SIZE               = 16,
  parameter int unsigned WIDTH              = 128,
  parameter int unsigned READ_LATENCY       = 1,
  parameter string       MODE_A             = "READ_FIRST",
  parameter string       MODE_B             = "READ_FIRST",
  parameter bit          CLEAR_ON_RESET     = 1'b1,
  parameter string       COLLISION_PRIORITY = "A"
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic                          busy,
  input  logic                          enA,
  input  logic [clog2_min1(SIZE)-1:0]   addrA,
  input  logic [WIDTH/8-1:0]            weA,
  input  logic [WIDTH-1:0]              dinA,
  output logic [WIDTH-1:0]              doutA,
  output logic                          rvalidA,
  input  logic                          enB,
  input  logic [clog2_min1(SIZE)-1:0]   addrB,
  input  logic [WIDTH/8-1:0]            weB,
  input  logic [WIDTH-1:0]              dinB,
  output logic [WIDTH-1:0]              doutB,
  output logic                          rvalidB,
  output logic                          collision
);

  localparam int unsigned AW = clog2_min1(SIZE);
  localparam int unsigned NB = WIDTH / 8;
  localparam mode_e MA = (MODE_A == "WRITE_FIRST") ? MODE_WRITE_FIRST :
                         (MODE_A == "NO_CHANGE")   ? MODE_NO_CHANGE   : MODE_READ_FIRST;
  localparam mode_e MB = (MODE_B == "WRITE_FIRST") ? MODE_WRITE_FIRST :
                         (MODE_B == "NO_CHANGE")   ? MODE_NO_CHANGE   : MODE_READ_FIRST;
  localparam bit PRIO_A = (COLLISION_PRIORITY != "B");

  logic [WIDTH-1:0] mem_q [SIZE];
  clr_state_e       state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic             collision_q;

  logic             acc_a, acc_b, inr_a, inr_b, wr_a, wr_b, wok_a, wok_b;
  logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, pd_a, pd_b;
  logic             pv_a, pv_b;
  logic             lo_en, hi_en;
  logic [AW-1:0]    lo_addr, hi_addr;
  logic [NB-1:0]    lo_we, hi_we;
  logic [WIDTH-1:0] lo_din, hi_din;

  assign busy      = (state_q == ST_CLEAR);
  assign collision = collision_q;

  // Acceptance, range check, old-word fetch and per-port byte merge.
  always_comb begin
    acc_a = enA && !busy && rstn;
    acc_b = enB && !busy && rstn;
    inr_a = 32'(addrA) < SIZE;
    inr_b = 32'(addrB) < SIZE;
    wr_a  = |weA;
    wr_b  = |weB;
    wok_a = acc_a && wr_a && inr_a;
    wok_b = acc_b && wr_b && inr_b;
    old_a = inr_a ? mem_q[addrA] : '0;
    old_b = inr_b ? mem_q[addrB] : '0;
    mrg_a = old_a;
    mrg_b = old_b;
    for (int unsigned i = 0; i < NB; i++) begin
      if (weA[i]) mrg_a[8*i +: 8] = dinA[8*i +: 8];
      if (weB[i]) mrg_b[8*i +: 8] = dinB[8*i +: 8];
    end
    pv_a = acc_a && (!wr_a || MA != MODE_NO_CHANGE);
    pv_b = acc_b && (!wr_b || MB != MODE_NO_CHANGE);
    pd_a = (wr_a && inr_a && MA == MODE_WRITE_FIRST) ? mrg_a : old_a;
    pd_b = (wr_b && inr_b && MB == MODE_WRITE_FIRST) ? mrg_b : old_b;
  end

  // Order the two write ports so the priority port is applied last.
  always_comb begin
    if (PRIO_A) begin
      lo_en = wok_b; lo_addr = addrB; lo_we = weB; lo_din = dinB;
      hi_en = wok_a; hi_addr = addrA; hi_we = weA; hi_din = dinA;
    end else begin
      lo_en = wok_a; lo_addr = addrA; lo_we = weA; lo_din = dinA;
      hi_en = wok_b; hi_addr = addrB; hi_we = weB; hi_din = dinB;
    end
  end

  // Storage: clear sweep, then byte writes; later NBAs give the winner overlapping bytes.
  always_ff @(posedge clk) begin
    if (rstn && busy) mem_q[clr_cnt_q] <= '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (lo_en && lo_we[i]) mem_q[lo_addr][8*i +: 8] <= lo_din[8*i +: 8];
      if (hi_en && hi_we[i]) mem_q[hi_addr][8*i +: 8] <= hi_din[8*i +: 8];
    end
  end

  // Clear sequencer: one word per cycle from address 0, then ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (32'(clr_cnt_q) == SIZE - 1) state_q <= ST_READY;
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Collision flag: same in-range address written by both ports with shared bytes.
  always_ff @(posedge clk) begin
    if (!rstn) collision_q <= 1'b0;
    else       collision_q <= wok_a && wok_b && (addrA == addrB) && |(weA & weB);
  end

  dp_mem_rd_pipe #(.WIDTH(WIDTH), .LATENCY(READ_LATENCY)) u_pipe_a (
    .clk_i(clk), .rstn_i(rstn), .valid_i(pv_a), .data_i(pd_a),
    .valid_o(rvalidA), .data_o(doutA)
  );

  dp_mem_rd_pipe #(.WIDTH(WIDTH), .LATENCY(READ_LATENCY)) u_pipe_b (
    .clk_i(clk), .rstn_i(rstn), .valid_i(pv_b), .data_i(pd_b),
    .valid_o(rvalidB), .data_o(doutB)
  );

endmodule

// File: tb/tb_dual_port_mem_pipe.sv
// Directed bench with per-port scoreboards for dual_port_mem_pipe.
module tb_dual_port_mem_pipe;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 2;

  typedef struct {
    int unsigned      due;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn, busy, collision;
  logic             enA, enB, rvalidA, rvalidB;
  logic [3:0]       addrA, addrB, weA, weB;
  logic [WIDTH-1:0] dinA, dinB, doutA, doutB;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned bcnt;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_mem_pipe #(
    .SIZE(SIZE), .WIDTH(WIDTH), .READ_LATENCY(LAT),
    .MODE_A("WRITE_FIRST"), .MODE_B("NO_CHANGE"),
    .CLEAR_ON_RESET(1'b1), .COLLISION_PRIORITY("A")
  ) dut (
    .clk(clk), .rstn(rstn), .busy(busy),
    .enA(enA), .addrA(addrA), .weA(weA), .dinA(dinA), .doutA(doutA), .rvalidA(rvalidA),
    .enB(enB), .addrB(addrB), .weB(weB), .dinB(dinB), .doutB(doutB), .rvalidB(rvalidB),
    .collision(collision)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  // One cycle of port activity; enables drop afterwards.
  task automatic acc(input logic ea, input logic [3:0] aa, input logic [3:0] wa, input logic [WIDTH-1:0] da,
                     input logic eb, input logic [3:0] ab, input logic [3:0] wb, input logic [WIDTH-1:0] db);
    enA = ea; addrA = aa; weA = wa; dinA = da;
    enB = eb; addrB = ab; weB = wb; dinB = db;
    tick();
    enA = 1'b0; weA = '0; enB = 1'b0; weB = '0;
  endtask

  task automatic push_a(input logic [WIDTH-1:0] d);
    qa.push_back('{cyc + LAT, d});
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d);
    qb.push_back('{cyc + LAT, d});
  endtask

  task automatic count_busy();
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      tick();
    end
    chk("busy_len", bcnt, SIZE);
  endtask

  // Scoreboard: outputs sampled on the falling edge against the queued expectations.
  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].due == cyc) begin
      chk("rvalidA", rvalidA, 1'b1);
      chk("doutA", doutA, qa[0].data);
      qa.delete(0);
    end else if (rvalidA) begin
      chk("rvalidA_spurious", rvalidA, 1'b0);
    end
    if (qb.size() != 0 && qb[0].due == cyc) begin
      chk("rvalidB", rvalidB, 1'b1);
      chk("doutB", doutB, qb[0].data);
      qb.delete(0);
    end else if (rvalidB) begin
      chk("rvalidB_spurious", rvalidB, 1'b0);
    end
  end

  initial begin
    rstn = 1'b0;
    enA = 1'b0; addrA = '0; weA = '0; dinA = '0;
    enB = 1'b0; addrB = '0; weB = '0; dinB = '0;
    idle(3);
    chk("rst_busy", busy, 1'b1);
    chk("rst_doutA", doutA, '0);
    chk("rst_rvalidA", rvalidA, 1'b0);
    chk("rst_doutB", doutB, '0);
    chk("rst_collision", collision, 1'b0);

    // Clear sequence after reset release.
    rstn = 1'b1;
    count_busy();
    for (int unsigned i = 0; i < SIZE; i++) begin
      push_a('0);
      push_b('0);
      acc(1'b1, 4'(i), 4'h0, '0, 1'b1, 4'(SIZE - 1 - i), 4'h0, '0);
    end
    idle(LAT + 1);

    // Port A byte writes in WRITE_FIRST mode.
    push_a(32'hAAAA_AAAA);
    acc(1'b1, 4'd3, 4'hF, 32'hAAAA_AAAA, 1'b0, '0, '0, '0);
    push_a(32'hAAAA_AA55);
    acc(1'b1, 4'd3, 4'h1, 32'h0000_0055, 1'b0, '0, '0, '0);
    push_a(32'hAAAA_AA55);
    acc(1'b1, 4'd3, 4'h0, '0, 1'b0, '0, '0, '0);

    // Cross-port read during write returns the old word.
    push_a(32'h0000_0001);
    push_b(32'h0000_0000);
    acc(1'b1, 4'd5, 4'hF, 32'h0000_0001, 1'b1, 4'd5, 4'h0, '0);
    push_b(32'h0000_0001);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd5, 4'h0, '0);
    idle(LAT + 1);

    // Full overlap collision: A wins byte 0.
    push_a(32'h0000_0011);
    acc(1'b1, 4'd7, 4'h1, 32'h0000_0011, 1'b1, 4'd7, 4'h1, 32'h0000_0022);
    chk("collision_pulse", collision, 1'b1);
    tick();
    chk("collision_clear", collision, 1'b0);
    push_b(32'h0000_0011);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd7, 4'h0, '0);

    // Partial overlap: A wins byte 1, B keeps byte 2.
    push_a(32'h0000_3344);
    acc(1'b1, 4'd8, 4'h3, 32'h0000_3344, 1'b1, 4'd8, 4'h6, 32'h0055_6600);
    chk("collision_partial", collision, 1'b1);
    push_b(32'h0055_3344);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd8, 4'h0, '0);

    // Disjoint bytes at one address do not collide.
    push_a(32'h0000_00C1);
    acc(1'b1, 4'd9, 4'h1, 32'h0000_00C1, 1'b1, 4'd9, 4'h8, 32'hD200_0000);
    chk("collision_disjoint", collision, 1'b0);
    push_a(32'hD200_00C1);
    acc(1'b1, 4'd9, 4'h0, '0, 1'b0, '0, '0, '0);
    idle(LAT + 1);

    // NO_CHANGE on port B: writes leave dout and rvalid untouched.
    acc(1'b0, '0, '0, '0, 1'b1, 4'd10, 4'hF, 32'h0000_0009);
    push_b(32'h0000_0009);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd10, 4'h0, '0);
    idle(LAT + 1);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd11, 4'hF, 32'h0000_0077);
    idle(LAT + 1);
    chk("nochange_hold", doutB, 32'h0000_0009);
    push_b(32'h0000_0077);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd11, 4'h0, '0);

    // Top address.
    push_a(32'hDEAD_BEEF);
    acc(1'b1, 4'd15, 4'hF, 32'hDEAD_BEEF, 1'b0, '0, '0, '0);
    push_b(32'hDEAD_BEEF);
    acc(1'b0, '0, '0, '0, 1'b1, 4'd15, 4'h0, '0);
    idle(LAT + 1);

    // Reset with reads in flight flushes the pipeline.
    acc(1'b1, 4'd3, 4'h0, '0, 1'b1, 4'd5, 4'h0, '0);
    rstn = 1'b0;
    tick();
    chk("flush_doutA", doutA, '0);
    chk("flush_rvalidA", rvalidA, 1'b0);
    chk("flush_doutB", doutB, '0);
    chk("flush_rvalidB", rvalidB, 1'b0);
    chk("flush_busy", busy, 1'b1);
    idle(2);

    // Reset during clear restarts the full sweep.
    rstn = 1'b1;
    idle(5);
    chk("midclear_busy", busy, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    count_busy();
    push_a('0);
    push_b('0);
    acc(1'b1, 4'd15, 4'h0, '0, 1'b1, 4'd3, 4'h0, '0);
    idle(LAT + 2);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
